n1_core: RTL and testbench
==========================

Name: n1_core

Overview:
- Parametrised successor to the n1 fetch-only skeleton: a complete two-phase (FETCH/EXEC) accumulator processor.
- Provides an external program-load port, a start/halt control FSM, data RAM, Z/C flags, conditional jumps, and a registered output strobe.
- Sits as the compute core behind the tile's pin wrapper.
  - Program is written through the load port while the core is idle.
  - Results leave through out_data/out_valid.

Parameters:
- PC_W, 5: program counter width; program RAM depth = 2^PC_W words of 16 bits.
- DATA_W, 8: accumulator, data RAM word and out_data width.
- DMEM_AW, 5: data RAM address width; depth = 2^DMEM_AW words.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  core enable; low freezes FSM, pc, acc, flags, data RAM.
- start  in  1  level sampled in IDLE/HALT: begin execution at pc=0.
- prog_we  in  1  program RAM write strobe.
- prog_addr  in  PC_W  program RAM write address.
- prog_data  in  16  program word.
- pc  out  PC_W  current program counter.
- acc  out  DATA_W  accumulator.
- out_data  out  DATA_W  value of last OUT instruction.
- out_valid  out  1  one-cycle strobe, out_data updated.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async, rst=1) sets these values; RAM contents are not reset.
  - state=IDLE, pc=0, acc=0, Z=0, C=0, inst=0.
  - out_data=0, out_valid=0, busy=0, halted=0.
- Reset mid-run: immediate return to IDLE; an in-flight ST is discarded.
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE/HALT with start=1 and ena=1 -> FETCH; pc=0, acc=0, Z=0, C=0.
  - FETCH -> EXEC: inst <= pram[pc]; pc <= pc+1, wrapping at 2^PC_W-1 -> 0.
  - EXEC -> FETCH, or -> HALT on the HALT opcode.
  - Each instruction takes 2 enabled cycles.
- ena=0: no state or register changes, except that out_valid drops to 0. Program writes remain governed only by the busy rule.
- Program load: pram[prog_addr] <= prog_data when prog_we=1 and busy=0. Writes are ignored while busy. start is ignored while busy.
- Instruction format: op=inst[15:12], operand k=inst[7:0]; inst[11:8] is reserved.
  - imm = k zero-extended or truncated to DATA_W.
  - a = k[DMEM_AW-1:0].
  - t = k[PC_W-1:0].
- Opcodes, executed in EXEC:
  - 0 NOP.
  - 1 LDI: acc=imm.
  - 2 LD: acc=dmem[a].
  - 3 ST: dmem[a]=acc.
  - 4 ADD: acc=acc+dmem[a].
  - 5 SUB: acc=acc-dmem[a].
  - 6 ADDI: acc=acc+imm.
  - 7 AND: acc=acc&dmem[a].
  - 8 OR: acc=acc|dmem[a].
  - 9 XOR: acc=acc^dmem[a].
  - A JMP: pc=t.
  - B JZ: pc=t if Z.
  - C JC: pc=t if C.
  - D OUT: out_data=acc, out_valid=1 next cycle.
  - E: reserved, treated as NOP.
  - F HALT.
- Flags:
  - Z=(new acc==0), updated by ops 1,2,4-9.
  - C updated only by ADD/ADDI (carry out of DATA_W) and by SUB (1 = borrow).
  - All other ops preserve the flags.
- Data RAM read is combinational within EXEC. ST writes at the end of EXEC.
- out_valid is registered: high exactly one cycle, the cycle after OUT's EXEC edge. out_data holds its value until the next OUT or reset.
- Untaken conditional jumps leave pc at its already-incremented value.

Test Plan:
- Reset: run a program, assert rst in EXEC -> outputs immediately at the reset values above; a later start executes from pc=0.
- Basic run (defaults): load LDI 5, ADDI 3, OUT, HALT at 0-3; start one cycle -> out_data=8 with out_valid high exactly 1 cycle, 6 cycles after FETCH entry; halted=1, busy=0 afterwards; pc=4.
- Flags: LDI 0xFF, ST 0, LDI 1, ADD 0, JC 10, NOP at 10 is HALT -> acc=0, Z=1, C=1, halts with pc=11; repeat with SUB 0 after LDI 0 -> acc=0x01, C=1 (borrow).
- Wrap: JMP 31; pram[31]=NOP; pram[0]=HALT -> pc goes 31 -> 0 -> halt; a second start reruns from 0.
- Stall: hold ena=0 for 3 cycles mid-program -> pc, acc and state are unchanged during the stall; final out_data is identical to the unstalled run.
- Guarding: prog_we and start pulses while busy=1 -> pram unchanged (read back by executing it), run not restarted; the same writes in HALT take effect.

Source files
------------

// File: rtl/n1_core.sv
// n1_core: two-phase (FETCH/EXEC) accumulator processor with a program-load port,
// a start/halt control FSM, data RAM, Z/C flags, conditional jumps and a registered output strobe.
module n1_core #(
    parameter int PC_W    = 5,
    parameter int DATA_W  = 8,
    parameter int DMEM_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              start,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [15:0]       prog_data,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
    typedef enum logic [3:0] {
        OP_NOP, OP_LDI, OP_LD, OP_ST, OP_ADD, OP_SUB, OP_ADDI, OP_AND,
        OP_OR, OP_XOR, OP_JMP, OP_JZ, OP_JC, OP_OUT, OP_RSV, OP_HALT
    } op_t;

    state_t              state_reg;
    logic [PC_W-1:0]     pc_reg;
    logic [DATA_W-1:0]   acc_reg;
    logic [DATA_W-1:0]   out_data_reg;
    logic [15:0]         inst_reg;
    logic                z_reg, c_reg;
    logic                out_valid_reg, busy_reg, halted_reg;

    logic [15:0]         pram [2**PC_W];
    logic [DATA_W-1:0]   dmem [2**DMEM_AW];

    op_t                 op;
    logic [DATA_W+7:0]   k_ext;
    logic [DATA_W-1:0]   imm, dmem_rd;
    logic [DMEM_AW-1:0]  dmem_addr;
    logic [PC_W-1:0]     jmp_tgt;
    logic [DATA_W:0]     sum_add, sum_addi, diff_sub;

    logic [DATA_W-1:0]   acc_next;
    logic [PC_W-1:0]     pc_next;
    logic                z_next, c_next, upd_z, st_we, out_fire, halt_op;
    logic                unused_bits;

    assign op        = op_t'(inst_reg[15:12]);
    assign k_ext     = {{DATA_W{1'b0}}, inst_reg[7:0]};
    assign imm       = k_ext[DATA_W-1:0];
    assign dmem_addr = inst_reg[DMEM_AW-1:0];
    assign jmp_tgt   = inst_reg[PC_W-1:0];
    assign dmem_rd   = dmem[dmem_addr];
    // The extra top bit of each result is the carry out (or borrow, for SUB).
    assign sum_add   = {1'b0, acc_reg} + {1'b0, dmem_rd};
    assign sum_addi  = {1'b0, acc_reg} + {1'b0, imm};
    assign diff_sub  = {1'b0, acc_reg} - {1'b0, dmem_rd};
    assign unused_bits = ^{inst_reg[11:8], k_ext[DATA_W+7:DATA_W]};

    always_comb begin
        acc_next = acc_reg;
        pc_next  = pc_reg;
        z_next   = z_reg;
        c_next   = c_reg;
        upd_z    = 1'b0;
        st_we    = 1'b0;
        out_fire = 1'b0;
        halt_op  = 1'b0;
        case (op)
            OP_LDI:  begin acc_next = imm;               upd_z = 1'b1; end
            OP_LD:   begin acc_next = dmem_rd;           upd_z = 1'b1; end
            OP_ST:   st_we = 1'b1;
            OP_ADD:  begin {c_next, acc_next} = sum_add;  upd_z = 1'b1; end
            OP_SUB:  begin {c_next, acc_next} = diff_sub; upd_z = 1'b1; end
            OP_ADDI: begin {c_next, acc_next} = sum_addi; upd_z = 1'b1; end
            OP_AND:  begin acc_next = acc_reg & dmem_rd; upd_z = 1'b1; end
            OP_OR:   begin acc_next = acc_reg | dmem_rd; upd_z = 1'b1; end
            OP_XOR:  begin acc_next = acc_reg ^ dmem_rd; upd_z = 1'b1; end
            OP_JMP:  pc_next = jmp_tgt;
            OP_JZ:   if (z_reg) pc_next = jmp_tgt;
            OP_JC:   if (c_reg) pc_next = jmp_tgt;
            OP_OUT:  out_fire = 1'b1;
            OP_HALT: halt_op = 1'b1;
            default: ;
        endcase
        if (upd_z) z_next = (acc_next == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            pc_reg        <= '0;
            acc_reg       <= '0;
            z_reg         <= 1'b0;
            c_reg         <= 1'b0;
            inst_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            halted_reg    <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            if (ena) begin
                case (state_reg)
                    S_IDLE, S_HALT: begin
                        if (start) begin
                            state_reg  <= S_FETCH;
                            busy_reg   <= 1'b1;
                            halted_reg <= 1'b0;
                            pc_reg     <= '0;
                            acc_reg    <= '0;
                            z_reg      <= 1'b0;
                            c_reg      <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        inst_reg  <= pram[pc_reg];
                        pc_reg    <= pc_reg + PC_W'(1);
                        state_reg <= S_EXEC;
                    end
                    S_EXEC: begin
                        acc_reg <= acc_next;
                        pc_reg  <= pc_next;
                        z_reg   <= z_next;
                        c_reg   <= c_next;
                        if (out_fire) begin
                            out_data_reg  <= acc_reg;
                            out_valid_reg <= 1'b1;
                        end
                        if (halt_op) begin
                            state_reg  <= S_HALT;
                            busy_reg   <= 1'b0;
                            halted_reg <= 1'b1;
                        end else begin
                            state_reg <= S_FETCH;
                        end
                    end
                    default: begin
                        state_reg  <= S_IDLE;
                        busy_reg   <= 1'b0;
                        halted_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Program loads depend only on the core being idle or halted, not on ena.
    always_ff @(posedge clk) begin
        if (prog_we && !busy_reg) pram[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (ena && state_reg == S_EXEC && st_we) dmem[dmem_addr] <= acc_reg;
    end

    assign pc        = pc_reg;
    assign acc       = acc_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign halted    = halted_reg;

endmodule

// File: tb/tb_n1_core.sv
// Self-checking bench for n1_core: instruction-level reference model compared every cycle,
// plus directed programs with hand-computed results and randomized program/control traffic.
module tb_n1_core;
    localparam int PC_W = 5, DATA_W = 8, DMEM_AW = 5;

    logic clk = 1'b0, rst = 1'b1, ena = 1'b1, start = 1'b0, prog_we = 1'b0;
    logic [PC_W-1:0]   prog_addr = '0;
    logic [15:0]       prog_data = '0;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] acc, out_data;
    logic              out_valid, busy, halted;

    int n_checks = 0, n_pass = 0;

    n1_core #(.PC_W(PC_W), .DATA_W(DATA_W), .DMEM_AW(DMEM_AW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .pc(pc), .acc(acc),
        .out_data(out_data), .out_valid(out_valid), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    endtask

    // Reference model: instruction-level behaviour with plain integer arithmetic.
    int m_pram[32], m_dmem[32];
    int m_pc, m_acc, m_z, m_c, m_inst, m_out, m_ov;
    bit m_run, m_exec_phase, m_halt;

    task automatic model_reset();
        m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_inst = 0; m_out = 0; m_ov = 0;
        m_run = 0; m_exec_phase = 0; m_halt = 0;
    endtask

    task automatic model_step();
        int op, k, a, s, nov;
        nov = 0;
        if (prog_we && !m_run) m_pram[prog_addr] = prog_data;
        if (ena) begin
            if (!m_run) begin
                if (start) begin
                    m_run = 1; m_exec_phase = 0; m_halt = 0;
                    m_pc = 0; m_acc = 0; m_z = 0; m_c = 0;
                end
            end else if (!m_exec_phase) begin
                m_inst = m_pram[m_pc];
                m_pc = (m_pc + 1) % 32;
                m_exec_phase = 1;
            end else begin
                m_exec_phase = 0;
                op = m_inst >> 12; k = m_inst & 255; a = k % 32;
                case (op)
                    1:  begin m_acc = k; m_z = (m_acc == 0); end
                    2:  begin m_acc = m_dmem[a]; m_z = (m_acc == 0); end
                    3:  m_dmem[a] = m_acc;
                    4:  begin s = m_acc + m_dmem[a]; m_c = (s > 255); m_acc = s % 256; m_z = (m_acc == 0); end
                    5:  begin m_c = (m_acc < m_dmem[a]); m_acc = (m_acc - m_dmem[a] + 256) % 256; m_z = (m_acc == 0); end
                    6:  begin s = m_acc + k; m_c = (s > 255); m_acc = s % 256; m_z = (m_acc == 0); end
                    7:  begin m_acc = m_acc & m_dmem[a]; m_z = (m_acc == 0); end
                    8:  begin m_acc = m_acc | m_dmem[a]; m_z = (m_acc == 0); end
                    9:  begin m_acc = m_acc ^ m_dmem[a]; m_z = (m_acc == 0); end
                    10: m_pc = k % 32;
                    11: if (m_z != 0) m_pc = k % 32;
                    12: if (m_c != 0) m_pc = k % 32;
                    13: begin m_out = m_acc; nov = 1; end
                    15: begin m_run = 0; m_halt = 1; end
                    default: ;
                endcase
            end
        end
        m_ov = nov;
    endtask

    // Compare process: outputs are stable mid-cycle; inputs change just after each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            chk("cyc_pc", pc, m_pc);
            chk("cyc_acc", acc, m_acc);
            chk("cyc_out_data", out_data, m_out);
            chk("cyc_out_valid", out_valid, m_ov);
            chk("cyc_busy", busy, int'(m_run));
            chk("cyc_halted", halted, int'(m_halt));
            if (!rst) model_step();
        end
    end

    logic [15:0] prog [32];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 16'hF000;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32; i++) begin
            prog_we = 1'b1; prog_addr = PC_W'(i); prog_data = prog[i];
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output int cycles, output bit wrapped);
        int prev;
        cycles = 0; wrapped = 0; prev = int'(pc);
        while (!halted && cycles < budget) begin
            tick();
            cycles++;
            if (prev == 31 && pc == 0) wrapped = 1;
            prev = int'(pc);
        end
        chk("halt_reached", halted, 1);
    endtask

    task automatic run_to_halt(input int budget, output int cycles, output bit wrapped);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_halt(budget, cycles, wrapped);
    endtask

    initial begin
        int cyc, first_ov, ov_width, total, ref_out;
        bit wrapped;
        logic [PC_W-1:0]   s_pc;
        logic [DATA_W-1:0] s_acc;

        repeat (3) tick();
        chk("rst_pc", pc, 0);
        chk("rst_acc", acc, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        rst = 1'b0;
        tick();

        // Give every data RAM word a known value.
        for (int blk = 0; blk < 4; blk++) begin
            clear_prog();
            prog[0] = 16'h1000 | 16'(17 * blk + 3);
            for (int j = 0; j < 8; j++) begin
                prog[1 + 2*j] = 16'h6025;
                prog[2 + 2*j] = 16'h3000 | 16'(blk * 8 + j);
            end
            load_prog();
            run_to_halt(200, cyc, wrapped);
        end

        // Basic run: LDI 5, ADDI 3, OUT, HALT.
        clear_prog();
        prog[0] = 16'h1005; prog[1] = 16'h6003; prog[2] = 16'hD000; prog[3] = 16'hF000;
        load_prog();
        start = 1'b1; tick(); start = 1'b0;
        first_ov = 0; ov_width = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (out_valid) begin
                if (first_ov == 0) first_ov = c;
                ov_width++;
            end
        end
        chk("basic_ov_cycle", first_ov, 6);
        chk("basic_ov_width", ov_width, 1);
        chk("basic_out_data", out_data, 8);
        chk("basic_halted", halted, 1);
        chk("basic_busy", busy, 0);
        chk("basic_pc", pc, 4);

        // Reset while executing ADDI.
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        chk("mid_acc_before_rst", acc, 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_acc", acc, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_halted", halted, 0);
        tick();
        rst = 1'b0;
        tick();
        run_to_halt(100, cyc, wrapped);
        chk("after_rst_out_data", out_data, 8);
        chk("after_rst_pc", pc, 4);

        // Carry out of ADD and taken JC.
        clear_prog();
        prog[0] = 16'h10FF; prog[1] = 16'h3000; prog[2] = 16'h1001; prog[3] = 16'h4000;
        prog[4] = 16'hC00A;
        load_prog();
        run_to_halt(100, cyc, wrapped);
        chk("flags_add_acc", acc, 0);
        chk("flags_add_pc", pc, 11);

        // Borrow from SUB and taken JC.
        prog[2] = 16'h1000; prog[3] = 16'h5000;
        load_prog();
        run_to_halt(100, cyc, wrapped);
        chk("flags_sub_acc", acc, 1);
        chk("flags_sub_pc", pc, 11);

        // pc wrap 31 -> 0; dmem[7] selects the path on each pass.
        clear_prog();
        prog[0] = 16'h1000; prog[1] = 16'h3007;
        load_prog();
        run_to_halt(100, cyc, wrapped);
        clear_prog();
        prog[0] = 16'h2007; prog[1] = 16'hB003; prog[2] = 16'hF000; prog[3] = 16'h1001;
        prog[4] = 16'h3007; prog[5] = 16'hA01F; prog[31] = 16'h0000;
        load_prog();
        run_to_halt(100, cyc, wrapped);
        chk("wrap_seen", int'(wrapped), 1);
        chk("wrap_pc", pc, 3);
        chk("wrap_cycles", cyc, 18);
        run_to_halt(100, cyc, wrapped);
        chk("rerun_cycles", cyc, 6);
        chk("rerun_pc", pc, 3);

        // Stall: same program with and without a 3-cycle ena gap.
        clear_prog();
        prog[0] = 16'h1005; prog[1] = 16'h6003; prog[2] = 16'h6004; prog[3] = 16'hD000;
        load_prog();
        run_to_halt(100, cyc, wrapped);
        ref_out = int'(out_data);
        chk("stall_ref_out", ref_out, 12);
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        ena = 1'b0;
        s_pc = pc; s_acc = acc;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc, int'(s_pc));
            chk("stall_acc", acc, int'(s_acc));
            chk("stall_busy", busy, 1);
        end
        ena = 1'b1;
        wait_halt(100, cyc, wrapped);
        chk("stall_out_data", out_data, ref_out);

        // Writes and start while busy are ignored; the same write in HALT takes effect.
        clear_prog();
        prog[0] = 16'h1005; prog[1] = 16'h6003; prog[2] = 16'hD000;
        load_prog();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        prog_we = 1'b1; prog_addr = '0; prog_data = 16'h1009; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        wait_halt(100, cyc, wrapped);
        total = cyc + 2;
        chk("guard_cycles", total, 8);
        chk("guard_out_data", out_data, 8);
        prog_we = 1'b1; prog_addr = '0; prog_data = 16'h1009;
        tick();
        prog_we = 1'b0;
        run_to_halt(100, cyc, wrapped);
        chk("guard_halt_write_out", out_data, 12);

        // Randomized programs with random ena, start and load traffic.
        for (int iter = 0; iter < 20; iter++) begin
            for (int i = 0; i < 32; i++) begin
                int op;
                op = $urandom_range(0, 15);
                if (op == 15 && $urandom_range(0, 3) != 0) op = 6;
                prog[i] = 16'((op << 12) | $urandom_range(0, 4095));
            end
            load_prog();
            start = 1'b1;
            for (int c = 0; c < 80; c++) begin
                tick();
                ena = ($urandom_range(0, 9) != 0);
                start = ($urandom_range(0, 19) == 0);
                prog_we = ($urandom_range(0, 9) == 0);
                prog_addr = PC_W'($urandom_range(0, 31));
                prog_data = 16'($urandom_range(0, 65535));
            end
            tick();
            prog_we = 1'b0; start = 1'b0; ena = 1'b1;
            if (iter % 3 == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
